branch_hazard_ctrl: RTL

- Hazard/stall sequencer for the ID-stage branch-resolution path.
- Decides when the decode-stage branch comparator cannot yet receive a correct operand through the EX/MEM forwarding muxes. In that case it holds fetch and decode, and injects bubbles into EX.
- Sequences the multi-cycle load-to-branch stall with an FSM and down-counter.
- Flushes IF/ID on a resolved taken branch or jump, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/branch_hazard_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage branch hazard stall sequencer with IF/ID flush and stall-cycle counter
// Ports: clk/reset (async, active-high); ID instruction fields (branchD, jumpD, use_rsD/use_rtD,
// rs_addrD/rt_addrD, branch_takenD); EX and MEM producer info (reg_write*, mem_to_reg*, write_reg_addr*);
// outputs stallF/stallD/flushE (stall), flushD (taken branch/jump), stall_busy (HOLD), stall_cycles (perf).
module branch_hazard_ctrl #(
  parameter int PERF_W      = 16,
  parameter int LW_BR_STALL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branchD,
  input  logic              jumpD,
  input  logic              use_rsD,
  input  logic              use_rtD,
  input  logic [4:0]        rs_addrD,
  input  logic [4:0]        rt_addrD,
  input  logic              reg_writeE,
  input  logic              mem_to_regE,
  input  logic [4:0]        write_reg_addrE,
  input  logic              reg_writeM,
  input  logic              mem_to_regM,
  input  logic [4:0]        write_reg_addrM,
  input  logic              branch_takenD,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              flushD,
  output logic              stall_busy,
  output logic [PERF_W-1:0] stall_cycles
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, need;
  logic [PERF_W-1:0] cyc_q, cyc_d;
  logic              dep_e, dep_m, stall;
  assign dep_e = reg_writeE & (write_reg_addrE != 5'd0) &
                 ((use_rsD & (write_reg_addrE == rs_addrD)) | (use_rtD & (write_reg_addrE == rt_addrD)));
  assign dep_m = reg_writeM & (write_reg_addrM != 5'd0) &
                 ((use_rsD & (write_reg_addrM == rs_addrD)) | (use_rtD & (write_reg_addrM == rt_addrD)));
  // Load feeding a branch needs the long stall; any other branch dependency or a plain load-use needs one cycle.
  assign need = (state_q != IDLE)                 ? 2'd0 :
                (branchD & dep_e & mem_to_regE)   ? 2'(LW_BR_STALL) :
                ((branchD & (dep_e | (dep_m & mem_to_regM))) | (dep_e & mem_to_regE)) ? 2'd1 : 2'd0;
  // Outputs are forced low while reset is held so a lingering hazard cannot leak through.
  assign stall        = ~reset & ((state_q == HOLD) | (need != 2'd0));
  assign stallF       = stall;
  assign stallD       = stall;
  assign flushE       = stall;
  // Comparator operands are stale while stalled, so the flush waits for the first free cycle.
  assign flushD       = ~reset & (jumpD | (branchD & branch_takenD)) & ~stall;
  assign stall_busy   = (state_q == HOLD);
  assign stall_cycles = cyc_q;
  assign state_d = (state_q == HOLD) ? ((cnt_q == 2'd1) ? IDLE : HOLD) : ((need >= 2'd2) ? HOLD : IDLE);
  assign cnt_d   = (state_q == HOLD) ? cnt_q - 2'd1 : ((need >= 2'd2) ? need - 2'd1 : 2'd0);
  assign cyc_d   = (stall & ~&cyc_q) ? cyc_q + PERF_W'(1) : cyc_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end
endmodule
